vin_wr_arbiter: RTL and testbench
=================================

Name: vin_wr_arbiter

Overview:
- Shares the single DDR2 write-burst port between CH_NUM video-input write channels, one per CVBS input path.
- Each channel presents a wr_burst_req/len/addr/data interface; the block grants one channel at a time with round-robin priority.
- It forwards the granted channel's request to memory and routes wr_burst_data_req and burst_finish back to that channel only.
- It sits in the mem_clk domain between the per-input frame-buffer write controllers and the memory controller.

Parameters:
- CH_NUM, 4: number of requesting channels (2..8).
- MEM_DATA_BITS, 32: memory data width.
- TIMEOUT_CYCLES, 4096: grant-to-burst_finish cycle limit before timeout_err is flagged.

Ports:
- mem_clk  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- ch_en  in  CH_NUM  per-channel enable mask.
- ch_wr_burst_req  in  CH_NUM  per-channel write request.
- ch_wr_burst_len  in  10*CH_NUM  packed burst lengths; channel i occupies [10*i+9:10*i].
- ch_wr_burst_addr  in  24*CH_NUM  packed burst start addresses.
- ch_wr_burst_data  in  MEM_DATA_BITS*CH_NUM  packed write data.
- ch_wr_burst_data_req  out  CH_NUM  data-read strobe to the granted channel.
- ch_burst_finish  out  CH_NUM  burst-done strobe to the granted channel.
- wr_burst_req  out  1  request to memory.
- wr_burst_len  out  10  length of the granted burst.
- wr_burst_addr  out  24  start address of the granted burst.
- wr_burst_data  out  MEM_DATA_BITS  write data.
- wr_burst_data_req  in  1  memory data strobe.
- burst_finish  in  1  memory burst-done strobe.
- grant_id  out  3  index of the current or last granted channel.
- busy  out  1  high while a grant is outstanding.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- FSM states: IDLE, GRANT, DONE.
- IDLE:
  - Eligible set = ch_wr_burst_req & ch_en.
  - If the set is non-empty, pick the first eligible index searching upward (modulo CH_NUM) from last_grant+1.
  - Register grant_id, latch len and addr, go to GRANT.
  - Decision is made from the cycle-n inputs; wr_burst_req, busy and the latched len/addr are valid at n+1.
- GRANT:
  - wr_burst_req=1 and stays high until burst_finish is seen.
  - wr_burst_data = ch_wr_burst_data[grant_id], combinational mux.
  - ch_wr_burst_data_req[grant_id] = wr_burst_data_req, combinational, 0-cycle latency; all other bits are 0.
  - On burst_finish: ch_burst_finish[grant_id]=1 in the same cycle (combinational). wr_burst_req drops the next cycle. last_grant<=grant_id. Go to DONE.
- DONE:
  - Lasts one cycle; no arbitration; wr_burst_req=0.
  - This absorbs a requester's stale req in the finish+1 cycle. Then go to IDLE.
- Len/addr are latched at grant. Changes on the channel inputs during GRANT are ignored.
- burst_finish or wr_burst_data_req arriving outside GRANT is ignored; nothing is forwarded.
- wr_burst_data_req and burst_finish in the same cycle: both are forwarded.
- A ch_en or ch_wr_burst_req deassert during GRANT does not abort the burst. The grant completes normally.
- Timeout:
  - A 16-bit counter clears at grant and increments in GRANT.
  - At TIMEOUT_CYCLES, timeout_err is set and stays set until rst.
  - The FSM keeps waiting for burst_finish; it never aborts.
- A single requester is re-granted back-to-back with a 2-cycle gap (DONE + IDLE decision).
- Reset values: wr_burst_req=0, wr_burst_len=0, wr_burst_addr=0, busy=0, grant_id=0, timeout_err=0, all ch_* outputs=0, state=IDLE.
- Reset also sets last_grant=CH_NUM-1, so channel 0 has first priority.
- Reset mid-burst: outputs return to reset values the next cycle; no finish is reported to the channel.
- busy=1 in GRANT and DONE, 0 in IDLE.

Test Plan:
- Single channel: ch2 req, len=64, addr=0x010000; memory asserts data_req for 64 cycles, then finish. -> wr_burst_req at n+1; len=64 and addr=0x010000 forwarded; exactly 64 ch_wr_burst_data_req[2] pulses; one ch_burst_finish[2] pulse; other channels' bits stay 0.
- All four channels request continuously, 8 bursts total. -> Grant order 0,1,2,3,0,1,2,3; 2-cycle gap between wr_burst_req high periods.
- ch_en=4'b1011 with all channels requesting. -> ch2 is never granted; order is 0,1,3,0,…
- ch1 changes addr and len mid-GRANT. -> Forwarded values stay as latched at grant; ch1 dropping req mid-burst does not drop wr_burst_req.
- TIMEOUT_CYCLES=100 and finish withheld for 150 cycles. -> timeout_err rises at cycle 100 after grant; the burst still completes at finish; timeout_err stays 1 until rst.
- rst pulsed mid-burst on ch3, then ch0 and ch3 request. -> All outputs return to 0 the next cycle; ch0 is granted first.

Source files
------------

// File: rtl/vin_wr_arbiter_if.sv
// Bundle of per-channel write-burst requests and the shared memory write port.
// The arbiter takes the master modport; channel/memory models take the slave modport.
interface vin_wr_arbiter_if #(
   parameter int CH_NUM        = 4,
   parameter int MEM_DATA_BITS = 32
);
   logic [CH_NUM-1:0]               ch_en;
   logic [CH_NUM-1:0]               ch_wr_burst_req;
   logic [10*CH_NUM-1:0]            ch_wr_burst_len;
   logic [24*CH_NUM-1:0]            ch_wr_burst_addr;
   logic [MEM_DATA_BITS*CH_NUM-1:0] ch_wr_burst_data;
   logic [CH_NUM-1:0]               ch_wr_burst_data_req;
   logic [CH_NUM-1:0]               ch_burst_finish;
   logic                            wr_burst_req;
   logic [9:0]                      wr_burst_len;
   logic [23:0]                     wr_burst_addr;
   logic [MEM_DATA_BITS-1:0]        wr_burst_data;
   logic                            wr_burst_data_req;
   logic                            burst_finish;
   logic [2:0]                      grant_id;
   logic                            busy;
   logic                            timeout_err;

   modport master (
      input  ch_en, ch_wr_burst_req, ch_wr_burst_len, ch_wr_burst_addr, ch_wr_burst_data,
      input  wr_burst_data_req, burst_finish,
      output ch_wr_burst_data_req, ch_burst_finish,
      output wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
      output grant_id, busy, timeout_err
   );

   modport slave (
      output ch_en, ch_wr_burst_req, ch_wr_burst_len, ch_wr_burst_addr, ch_wr_burst_data,
      output wr_burst_data_req, burst_finish,
      input  ch_wr_burst_data_req, ch_burst_finish,
      input  wr_burst_req, wr_burst_len, wr_burst_addr, wr_burst_data,
      input  grant_id, busy, timeout_err
   );
endinterface

// File: rtl/vin_wr_arbiter.sv
// Round-robin arbiter sharing one DDR write-burst port among CH_NUM channels; grant is
// registered (req valid one cycle after decision), data strobe/finish routed back combinationally.
module vin_wr_arbiter #(
   parameter int CH_NUM         = 4,
   parameter int MEM_DATA_BITS  = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              mem_clk,
   input  logic              rst,
   vin_wr_arbiter_if.master  bus
);
   localparam int IDXW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       grant_id_q, grant_id_d;
   logic [2:0]       last_grant_q, last_grant_d;
   logic [9:0]       len_q, len_d;
   logic [23:0]      addr_q, addr_d;
   logic [15:0]      tmo_cnt_q, tmo_cnt_d;
   logic             timeout_err_q, timeout_err_d;

   logic [CH_NUM-1:0]        eligible;
   logic [IDXW-1:0]          idx;
   logic                     pick_vld;
   logic [2:0]               pick_id;
   logic [9:0]               pick_len;
   logic [23:0]              pick_addr;
   logic                     in_grant;
   logic [CH_NUM-1:0]        ch_data_req;
   logic [CH_NUM-1:0]        ch_finish;
   logic [MEM_DATA_BITS-1:0] wr_data;

   // Search downward so the smallest offset from last_grant+1 is the final assignment.
   always_comb begin : rr_pick
      eligible  = bus.ch_wr_burst_req & bus.ch_en;
      idx       = '0;
      pick_vld  = 1'b0;
      pick_id   = '0;
      pick_len  = '0;
      pick_addr = '0;
      for (int k = CH_NUM; k >= 1; k--) begin
         idx = IDXW'((int'(last_grant_q) + k) % CH_NUM);
         if (eligible[idx]) begin
            pick_vld = 1'b1;
            pick_id  = 3'(idx);
         end
      end
      for (int i = 0; i < CH_NUM; i++) begin
         if (pick_id == 3'(i)) begin
            pick_len  = bus.ch_wr_burst_len[10*i +: 10];
            pick_addr = bus.ch_wr_burst_addr[24*i +: 24];
         end
      end
   end

   always_comb begin : next_state
      state_d       = state_q;
      grant_id_d    = grant_id_q;
      last_grant_d  = last_grant_q;
      len_d         = len_q;
      addr_d        = addr_q;
      tmo_cnt_d     = tmo_cnt_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_id_d = pick_id;
               len_d      = pick_len;
               addr_d     = pick_addr;
               tmo_cnt_d  = '0;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
            // Flag only; the burst is never aborted, we keep waiting for finish.
            if (tmo_cnt_d >= TMO_LIM) timeout_err_d = 1'b1;
            if (bus.burst_finish) begin
               last_grant_d = grant_id_q;
               state_d      = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : route
      in_grant    = (state_q == GRANT);
      ch_data_req = '0;
      ch_finish   = '0;
      wr_data     = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (in_grant && grant_id_q == 3'(i)) begin
            ch_data_req[i] = bus.wr_burst_data_req;
            ch_finish[i]   = bus.burst_finish;
            wr_data        = bus.ch_wr_burst_data[MEM_DATA_BITS*i +: MEM_DATA_BITS];
         end
      end
   end

   always_ff @(posedge mem_clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_id_q    <= '0;
         last_grant_q  <= 3'(CH_NUM - 1);
         len_q         <= '0;
         addr_q        <= '0;
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         last_grant_q  <= last_grant_d;
         len_q         <= len_d;
         addr_q        <= addr_d;
         tmo_cnt_q     <= tmo_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.wr_burst_req         = in_grant;
   assign bus.wr_burst_len         = len_q;
   assign bus.wr_burst_addr        = addr_q;
   assign bus.wr_burst_data        = wr_data;
   assign bus.ch_wr_burst_data_req = ch_data_req;
   assign bus.ch_burst_finish      = ch_finish;
   assign bus.grant_id             = grant_id_q;
   assign bus.busy                 = (state_q != IDLE);
   assign bus.timeout_err          = timeout_err_q;
endmodule

// File: tb/tb_vin_wr_arbiter.sv
// Scoreboard bench for vin_wr_arbiter: expected grants are queued as requests are driven and
// checked as wr_burst_req rises; a memory model drives data strobes and finish.
module tb_vin_wr_arbiter;
   localparam int TMO = 100;

   typedef struct {
      int         ch;
      logic [9:0] len;
      logic [23:0] addr;
   } exp_t;

   logic mem_clk;
   logic rst;

   vin_wr_arbiter_if #(.CH_NUM(4), .MEM_DATA_BITS(32)) bus ();

   vin_wr_arbiter #(.CH_NUM(4), .MEM_DATA_BITS(32), .TIMEOUT_CYCLES(TMO)) dut (
      .mem_clk (mem_clk),
      .rst     (rst),
      .bus     (bus)
   );

   initial mem_clk = 1'b0;
   always #5 mem_clk = ~mem_clk;

   int          n_cmp = 0;
   int          n_err = 0;
   int          rel   = 0;
   int          rr_last = 3;
   exp_t        exp_q[$];
   logic [9:0]  len_tab[4];
   logic [23:0] addr_tab[4];
   logic [31:0] dat_tab[4];
   logic [3:0]  ch_req;
   logic [3:0]  en_mask;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge mem_clk);
      #1;
      rel++;
   endtask

   task automatic apply();
      for (int i = 0; i < 4; i++) begin
         bus.ch_wr_burst_len[10*i +: 10]  = len_tab[i];
         bus.ch_wr_burst_addr[24*i +: 24] = addr_tab[i];
         bus.ch_wr_burst_data[32*i +: 32] = dat_tab[i];
      end
      bus.ch_wr_burst_req = ch_req;
      bus.ch_en           = en_mask;
   endtask

   task automatic set_tables();
      for (int i = 0; i < 4; i++) begin
         len_tab[i]  = 10'(4 + i);
         addr_tab[i] = 24'h100000 + 24'(i * 24'h001100);
         dat_tab[i]  = 32'hC0DE_0000 + 32'(i * 17);
      end
   endtask

   // Reference round-robin: first eligible channel upward from the last grant.
   task automatic push_n(input logic [3:0] m, input int n);
      exp_t e;
      int   g;
      for (int j = 0; j < n; j++) begin
         g = -1;
         for (int k = 4; k >= 1; k--) begin
            if (m[(rr_last + k) % 4]) g = (rr_last + k) % 4;
         end
         e.ch   = g;
         e.len  = len_tab[g];
         e.addr = addr_tab[g];
         exp_q.push_back(e);
         rr_last = g;
      end
   endtask

   task automatic do_reset();
      @(negedge mem_clk);
      rst = 1'b1;
      repeat (2) @(negedge mem_clk);
      rst = 1'b0;
      #1;
      rr_last = 3;
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_req"},   32'(bus.wr_burst_req), 0);
      chk({pfx, "_len"},   32'(bus.wr_burst_len), 0);
      chk({pfx, "_addr"},  32'(bus.wr_burst_addr), 0);
      chk({pfx, "_busy"},  32'(bus.busy), 0);
      chk({pfx, "_gid"},   32'(bus.grant_id), 0);
      chk({pfx, "_tmo"},   32'(bus.timeout_err), 0);
      chk({pfx, "_chdrq"}, 32'(bus.ch_wr_burst_data_req), 0);
      chk({pfx, "_chfin"}, 32'(bus.ch_burst_finish), 0);
   endtask

   // Memory model for one burst: wait for grant, compare against the scoreboard,
   // strobe len data words, optionally stall, then finish.
   task automatic serve(input int stall_to, input bit mutate, input bit rel_all, output int gap);
      exp_t       e;
      int         t, pulses, bad;
      logic [3:0] oh;
      t = 0;
      while (bus.wr_burst_req !== 1'b1 && t < 300) begin
         step();
         t++;
      end
      gap = t;
      if (bus.wr_burst_req !== 1'b1) begin
         chk("grant_wait", 0, 1);
         return;
      end
      if (exp_q.size() == 0) begin
         chk("sb_unexpected_grant", 32'(bus.grant_id), 32'hFFFF_FFFF);
         return;
      end
      e   = exp_q.pop_front();
      rel = 0;
      oh  = 4'b0001 << e.ch;
      chk("grant_id", 32'(bus.grant_id), 32'(e.ch));
      chk("len",      32'(bus.wr_burst_len), 32'(e.len));
      chk("addr",     32'(bus.wr_burst_addr), 32'(e.addr));
      chk("busy",     32'(bus.busy), 1);
      pulses = 0;
      bad    = 0;
      for (int k = 0; k < int'(e.len); k++) begin
         bus.wr_burst_data_req = 1'b1;
         #1;
         if (bus.ch_wr_burst_data_req == oh) pulses++;
         else bad++;
         if (bus.wr_burst_data !== dat_tab[e.ch]) bad++;
         if (mutate && k == 2) begin
            len_tab[1]  = 10'd99;
            addr_tab[1] = 24'hFFFFFF;
            ch_req[1]   = 1'b0;
            apply();
         end
         step();
      end
      bus.wr_burst_data_req = 1'b0;
      chk("data_pulses", 32'(pulses), 32'(e.len));
      chk("data_bad", 32'(bad), 0);
      if (mutate) begin
         chk("len_latched",  32'(bus.wr_burst_len), 32'(e.len));
         chk("addr_latched", 32'(bus.wr_burst_addr), 32'(e.addr));
         chk("req_held",     32'(bus.wr_burst_req), 1);
      end
      while (stall_to > 0 && rel < stall_to) begin
         if (rel == TMO - 1) chk("tmo_early", 32'(bus.timeout_err), 0);
         if (rel == TMO)     chk("tmo_set", 32'(bus.timeout_err), 1);
         step();
      end
      if (stall_to > 0) chk("req_after_stall", 32'(bus.wr_burst_req), 1);
      bus.burst_finish = 1'b1;
      #1;
      chk("fin_onehot", 32'(bus.ch_burst_finish), 32'(oh));
      step();
      bus.burst_finish = 1'b0;
      #1;
      chk("done_req",  32'(bus.wr_burst_req), 0);
      chk("done_busy", 32'(bus.busy), 1);
      chk("done_fin",  32'(bus.ch_burst_finish), 0);
      if (rel_all) begin
         // Requests stay high through DONE and drop in IDLE: DONE must not arbitrate.
         step();
         ch_req = 4'b0000;
         apply();
         repeat (3) step();
         chk("no_regrant", 32'(bus.wr_burst_req), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      int t;
      rst                   = 1'b1;
      bus.wr_burst_data_req = 1'b0;
      bus.burst_finish      = 1'b0;
      ch_req                = 4'b0000;
      en_mask               = 4'b1111;
      set_tables();
      apply();

      // Reset state
      do_reset();
      chk_zero("rst");

      // Single channel 2, 64-word burst
      len_tab[2]  = 10'd64;
      addr_tab[2] = 24'h010000;
      ch_req      = 4'b0100;
      apply();
      push_n(ch_req & en_mask, 1);
      serve(0, 0, 1, gap);
      chk("single_gap", 32'(gap), 1);

      // All four requesting continuously: 0,1,2,3,0,1,2,3 with a 2-cycle gap
      do_reset();
      set_tables();
      ch_req = 4'b1111;
      apply();
      push_n(ch_req & en_mask, 8);
      for (int b = 0; b < 8; b++) begin
         serve(0, 0, (b == 7), gap);
         if (b > 0) chk("rr_gap", 32'(gap), 2);
      end

      // Channel 2 masked off
      do_reset();
      en_mask = 4'b1011;
      ch_req  = 4'b1111;
      apply();
      push_n(ch_req & en_mask, 6);
      for (int b = 0; b < 6; b++) serve(0, 0, (b == 5), gap);
      en_mask = 4'b1111;

      // Channel 1 changes len/addr and drops req mid-grant
      do_reset();
      set_tables();
      len_tab[1]  = 10'd16;
      addr_tab[1] = 24'h0A0000;
      ch_req      = 4'b0010;
      apply();
      push_n(ch_req & en_mask, 1);
      serve(0, 1, 1, gap);

      // Timeout: finish withheld to 150 cycles after grant
      do_reset();
      set_tables();
      ch_req = 4'b0001;
      apply();
      push_n(ch_req & en_mask, 1);
      serve(150, 0, 1, gap);
      chk("tmo_sticky", 32'(bus.timeout_err), 1);

      // Reset mid-burst on channel 3, then ch0 and ch3 request
      ch_req = 4'b1000;
      apply();
      t = 0;
      while (bus.wr_burst_req !== 1'b1 && t < 50) begin
         step();
         t++;
      end
      chk("mid_grant3", 32'(bus.grant_id), 3);
      bus.wr_burst_data_req = 1'b1;
      #1;
      chk("mid_fwd", 32'(bus.ch_wr_burst_data_req), 32'h8);
      @(negedge mem_clk);
      rst = 1'b1;
      @(negedge mem_clk);
      #1;
      chk_zero("midrst");
      bus.burst_finish = 1'b1;
      #1;
      chk("midrst_nofin", 32'(bus.ch_burst_finish), 0);
      chk("midrst_nodrq", 32'(bus.ch_wr_burst_data_req), 0);
      bus.burst_finish      = 1'b0;
      bus.wr_burst_data_req = 1'b0;
      ch_req = 4'b1001;
      apply();
      @(negedge mem_clk);
      rst = 1'b0;
      #1;
      rr_last = 3;
      push_n(ch_req & en_mask, 2);
      serve(0, 0, 0, gap);
      serve(0, 0, 1, gap);

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
